// File: rtl/gate_exerciser.sv
// gate_exerciser: walks all 32 {g,e,d,b,a} vectors through the gate block and checks c=a&b, f=d|e, h=~g.
// Each vector is held SETTLE_CYCLES cycles, then checked for one cycle; errors and the first failure are recorded.
module gate_exerciser #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       drv_a,
   output logic       drv_b,
   output logic       drv_d,
   output logic       drv_e,
   output logic       drv_g,
   input  logic       obs_c,
   input  logic       obs_f,
   input  logic       obs_h,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [5:0] err_count,
   output logic [4:0] first_fail_vec,
   output logic [2:0] first_fail_obs
);
   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
   state_t state, state_n;
   logic [4:0] vec, vec_n, drv, drv_n, ffv_n;
   logic [3:0] cnt, cnt_n;
   logic [5:0] err_n;
   logic [2:0] ffo_n, exp_v, obs;
   logic pass_n, bad;
   assign obs = {obs_c, obs_f, obs_h};
   assign exp_v = {vec[0] & vec[1], vec[2] | vec[3], ~vec[4]};
   assign bad = (state == CHECK) && (obs != exp_v);
   assign {drv_g, drv_e, drv_d, drv_b, drv_a} = drv;
   assign busy = (state == SETTLE) || (state == CHECK);
   assign done = state == DONE;
   always_comb begin
      state_n = state;
      vec_n = vec;
      cnt_n = cnt;
      err_n = err_count;
      ffv_n = first_fail_vec;
      ffo_n = first_fail_obs;
      pass_n = pass;
      case (state)
         IDLE: if (start) begin
            state_n = SETTLE;
            vec_n = '0;
            cnt_n = '0;
            err_n = '0;
            ffv_n = '0;
            ffo_n = '0;
            pass_n = 1'b0;
         end
         SETTLE: begin
            cnt_n = cnt + 4'd1;
            state_n = (cnt == 4'(SETTLE_CYCLES - 1)) ? CHECK : SETTLE;
         end
         CHECK: begin
            if (bad) begin
               err_n = err_count + 6'd1;
               ffv_n = (err_count == 6'd0) ? vec : first_fail_vec;
               ffo_n = (err_count == 6'd0) ? obs : first_fail_obs;
            end
            if (vec == 5'd31) begin
               state_n = DONE;
               pass_n = err_n == 6'd0;
            end else begin
               state_n = SETTLE;
               vec_n = vec + 5'd1;
               cnt_n = '0;
            end
         end
         default: state_n = IDLE;
      endcase
      // drive pins are registered copies of the vector being exercised, zero otherwise
      drv_n = (state_n == SETTLE || state_n == CHECK) ? vec_n : 5'd0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         vec <= '0;
         cnt <= '0;
         drv <= '0;
         err_count <= '0;
         first_fail_vec <= '0;
         first_fail_obs <= '0;
         pass <= 1'b0;
      end else begin
         state <= state_n;
         vec <= vec_n;
         cnt <= cnt_n;
         drv <= drv_n;
         err_count <= err_n;
         first_fail_vec <= ffv_n;
         first_fail_obs <= ffo_n;
         pass <= pass_n;
      end
   end
endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: two exercisers (SETTLE_CYCLES 2 and 1) against faultable gate-block models,
// with a per-run expectation queue drained by a monitor on each done pulse.
module tb_gate_exerciser;
   typedef struct {int err; int fv; int fo; int pass; int blen;} exp_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [1:0] start = 2'b00, busy, done, pass;
   logic [4:0] drv0, drv1, p1, p2, ffv [2];
   logic [5:0] errc [2];
   logic [2:0] ffo [2], o0, o1;
   int mode0 = 0, mode1 = 3, checks = 0, errors = 0, bc [2] = '{0, 0};
   logic [1:0] prev_done = 2'b00;
   exp_t q0[$], q1[$];

   always #5 clk = ~clk;

   function automatic logic [2:0] gate(input logic [4:0] v);
      return {v[0] & v[1], v[2] | v[3], ~v[4]};
   endfunction

   assign o0 = gate(drv0) & ((mode0 == 1) ? 3'b011 : 3'b111) ^ ((mode0 == 2) ? 3'b001 : 3'b000);
   assign o1 = gate((mode1 == 4) ? p2 : p1);
   always @(posedge clk) begin
      p1 <= rst_n ? drv1 : 5'd0;
      p2 <= rst_n ? p1 : 5'd0;
   end

   gate_exerciser #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start[0]),
      .drv_a(drv0[0]), .drv_b(drv0[1]), .drv_d(drv0[2]), .drv_e(drv0[3]), .drv_g(drv0[4]),
      .obs_c(o0[2]), .obs_f(o0[1]), .obs_h(o0[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
      .first_fail_vec(ffv[0]), .first_fail_obs(ffo[0]));

   gate_exerciser #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]),
      .drv_a(drv1[0]), .drv_b(drv1[1]), .drv_d(drv1[2]), .drv_e(drv1[3]), .drv_g(drv1[4]),
      .obs_c(o1[2]), .obs_f(o1[1]), .obs_h(o1[0]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
      .first_fail_vec(ffv[1]), .first_fail_obs(ffo[1]));

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // What a gate block in the given fault mode answers when vector v is checked (settle=1 for modes 3/4)
   function automatic logic [2:0] obs_of(input int mode, input int v);
      logic [2:0] g;
      g = gate(5'(v));
      if (mode == 1) return {1'b0, g[1:0]};
      if (mode == 2) return {g[2:1], ~g[0]};
      if (mode == 4) return gate(5'((v == 0) ? 0 : v - 1));
      return g;
   endfunction

   function automatic exp_t model(input int mode, input int s);
      exp_t e;
      e = '{0, 0, 0, 0, 32 * (s + 1)};
      for (int v = 0; v < 32; v++)
         if (obs_of(mode, v) != gate(5'(v))) begin
            if (e.err == 0) begin
               e.fv = v;
               e.fo = int'(obs_of(mode, v));
            end
            e.err++;
         end
      e.pass = (e.err == 0) ? 1 : 0;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (done[k]) begin
            chk("done_pulse_width", int'(prev_done[k]), 0);
            if ((k == 0 ? q0.size() : q1.size()) == 0) chk("unexpected_done", 1, 0);
            else begin
               e = (k == 0) ? q0.pop_front() : q1.pop_front();
               chk("err_count", int'(errc[k]), e.err);
               chk("pass", int'(pass[k]), e.pass);
               chk("busy_cycles", bc[k], e.blen);
               if (e.err != 0) begin
                  chk("first_fail_vec", int'(ffv[k]), e.fv);
                  chk("first_fail_obs", int'(ffo[k]), e.fo);
               end
            end
            bc[k] = 0;
         end else if (busy[k]) bc[k]++;
         else bc[k] = 0;
         prev_done[k] = done[k];
      end
   end

   task automatic kick(input int k, input int mode);
      if (k == 0) begin
         mode0 = mode;
         q0.push_back(model(mode, 2));
      end else begin
         mode1 = mode;
         q1.push_back(model(mode, 1));
      end
      @(posedge clk);
      #1 start[k] = 1'b1;
      @(posedge clk);
      #1 start[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      while ((k == 0 ? q0.size() : q1.size()) != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("run_timeout", n < 1000 ? 1 : 0, 1);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", int'({busy, done, pass, errc[0], ffv[0], ffo[0], drv0}), 0);
      rst_n = 1'b1;
      kick(0, 0); wait_idle(0);
      kick(0, 1); wait_idle(0);
      kick(0, 2); wait_idle(0);
      kick(0, 0); wait_idle(0);
      for (int i = 0; i < 3; i++) begin
         kick(0, int'($urandom_range(0, 2)));
         repeat ($urandom_range(5, 80)) @(posedge clk);
         #1 start[0] = 1'b1;
         @(posedge clk);
         #1 start[0] = 1'b0;
         wait_idle(0);
      end
      mode0 = 1;
      q0.push_back(model(1, 2));
      q0.push_back(model(1, 2));
      @(posedge clk);
      #1 start[0] = 1'b1;
      n = 0;
      while ((q0.size() > 1 || !busy[0]) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("back_to_back_restart", int'(busy[0]), 1);
      start[0] = 1'b0;
      wait_idle(0);
      kick(0, 0);
      n = 0;
      while (drv0 != 5'd10 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("reach_vec10", int'(drv0), 10);
      rst_n = 1'b0;
      q0.delete();
      @(negedge clk);
      chk("abort_outputs", int'({busy[0], done[0], pass[0], errc[0], ffv[0], ffo[0], drv0}), 0);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      kick(0, 2); wait_idle(0);
      kick(1, 3); wait_idle(1);
      kick(1, 4); wait_idle(1);
      kick(1, 3); wait_idle(1);
      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
